// File: rtl/nibble_add_sched.sv
// Two-requester round-robin scheduler that runs WIDTH-bit adds nibble-serially through one
// shared external 4-bit adder slice, LSB nibble first, with the carry registered between nibbles.
module nibble_add_sched #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout
);

    localparam int unsigned NNIB = WIDTH / 4;
    localparam int unsigned KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e                 state_q;
    logic [NNIB-1:0][3:0]   a_q;
    logic [NNIB-1:0][3:0]   b_q;
    logic [NNIB-1:0][3:0]   sum_q;
    logic                   carry_q;
    logic                   id_q;
    logic                   last_q;
    logic [KW-1:0]          k_q;

    logic gnt1;
    logic idle;
    logic accept;

    // last_q holds the requester served last; on contention the other one wins.
    assign idle   = (state_q == StIdle);
    assign gnt1   = req1_valid & (~req0_valid | ~last_q);
    assign accept = idle & (req0_valid | req1_valid);

    // Gated by rst_n so the handshake is silent while reset is held.
    assign req0_ready = rst_n & idle & req0_valid & ~gnt1;
    assign req1_ready = rst_n & idle & gnt1;

    assign busy      = ~idle;
    assign rsp_valid = (state_q == StDone);
    assign rsp_sum   = rsp_valid ? sum_q : '0;
    assign rsp_cout  = rsp_valid & carry_q;
    assign rsp_id    = rsp_valid & id_q;

    always_comb begin
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;
        if (state_q == StAdd) begin
            slice_a   = a_q[k_q];
            slice_b   = b_q[k_q];
            slice_cin = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            k_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= gnt1 ? req1_a : req0_a;
                        b_q     <= gnt1 ? req1_b : req0_b;
                        carry_q <= gnt1 ? req1_cin : req0_cin;
                        id_q    <= gnt1;
                        last_q  <= gnt1;
                        k_q     <= '0;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    sum_q[k_q] <= slice_sum;
                    carry_q    <= slice_cout;
                    if (k_q == KW'(NNIB - 1)) begin
                        state_q <= StDone;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched: a WIDTH=16 instance for carry ripple, arbitration,
// backpressure and mid-operation reset, plus a WIDTH=4 instance swept over every operand pair.
module tb_nibble_add_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
    logic [15:0] rsp_sum;
    logic [3:0]  slice_a, slice_b, slice_sum;
    logic        slice_cin, slice_cout;

    logic        e_v0, e_r0, e_c0, e_v1, e_r1, e_c1;
    logic [3:0]  e_a0, e_b0, e_a1, e_b1;
    logic        e_rv, e_rr, e_cout, e_id, e_busy;
    logic [3:0]  e_sum, e_sa, e_sb, e_ss;
    logic        e_sc, e_sco;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit adder slices.
    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);
    assign {e_sco, e_ss}           = 5'(e_sa) + 5'(e_sb) + 5'(e_sc);

    nibble_add_sched #(.WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .busy(busy),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_cout(slice_cout)
    );

    nibble_add_sched #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(e_v0), .req0_ready(e_r0), .req0_a(e_a0), .req0_b(e_b0), .req0_cin(e_c0),
        .req1_valid(e_v1), .req1_ready(e_r1), .req1_a(e_a1), .req1_b(e_b1), .req1_cin(e_c1),
        .rsp_valid(e_rv), .rsp_ready(e_rr), .rsp_sum(e_sum), .rsp_cout(e_cout),
        .rsp_id(e_id), .busy(e_busy),
        .slice_a(e_sa), .slice_b(e_sb), .slice_cin(e_sc),
        .slice_sum(e_ss), .slice_cout(e_sco)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_sum"}, 32'(rsp_sum), 32'd0);
        chk({tag, ".rsp_cout"}, 32'(rsp_cout), 32'd0);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, ".slice"}, {23'd0, slice_cin, slice_a, slice_b}, 32'd0);
        chk({tag, ".ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    endtask

    int g_id [4];
    int g_cyc[4];
    int r_sum[4];
    int r_id [4];
    int ng, nr;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b0;
        e_v0 = 1'b0; e_a0 = '0; e_b0 = '0; e_c0 = 1'b0;
        e_v1 = 1'b0; e_a1 = '0; e_b1 = '0; e_c1 = 1'b0;
        e_rr = 1'b1;

        // Reset state, with requests pending so ready gating is exercised.
        tick(); tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        chk_all_zero("reset");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Carry ripple: 0xFFFF + 0x0001.
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_cin = 1'b0;
        settle();
        chk("ripple.ready0", 32'(req0_ready), 32'd1);
        chk("ripple.ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("ripple.ready0_drop", 32'(req0_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("ripple.slice_cin", 32'(slice_cin), (i == 0) ? 32'd0 : 32'd1);
            chk("ripple.slice_a", 32'(slice_a), 32'hF);
            chk("ripple.slice_b", 32'(slice_b), (i == 0) ? 32'd1 : 32'd0);
            chk("ripple.no_rsp", 32'(rsp_valid), 32'd0);
            tick(); settle();
        end
        chk("ripple.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ripple.rsp_sum", 32'(rsp_sum), 32'h0000);
        chk("ripple.rsp_cout", 32'(rsp_cout), 32'd1);
        chk("ripple.rsp_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        tick(); settle();
        chk("ripple.rsp_drop", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Carry-in on requester 1: 0x1234 + 0x4321 + 1.
        req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h4321; req1_cin = 1'b1;
        settle();
        chk("cin.ready1", 32'(req1_ready), 32'd1);
        chk("cin.ready0", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        req1_a = 16'hDEAD; req1_b = 16'hBEEF;
        repeat (4) tick();
        settle();

        // Backpressure: response held for 5 cycles while requester 0 waits.
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp.rsp_sum", 32'(rsp_sum), 32'h5556);
            chk("bp.rsp_cout", 32'(rsp_cout), 32'd0);
            chk("bp.rsp_id", 32'(rsp_id), 32'd1);
            chk("bp.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        chk("bp.no_accept_in_done", 32'(req0_ready), 32'd0);
        tick(); settle();
        chk("bp.rsp_drop", 32'(rsp_valid), 32'd0);
        chk("bp.next_grant", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        repeat (4) tick();
        settle();
        chk("bp.next_sum", 32'(rsp_sum), 32'h0002);
        chk("bp.next_id", 32'(rsp_id), 32'd0);
        tick();

        // Arbitration after reset with both requesters held valid.
        rst_n = 1'b0;
        settle();
        rst_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002; req1_cin = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g_id[i] = -1; g_cyc[i] = -100; r_sum[i] = -1; r_id[i] = -1;
        end
        ng = 0; nr = 0;
        settle();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if ((req0_ready || req1_ready) && ng < 4) begin
                g_id[ng] = int'(req1_ready); g_cyc[ng] = cyc; ng++;
            end
            if (rsp_valid && nr < 4) begin
                r_sum[nr] = int'(rsp_sum); r_id[nr] = int'(rsp_id); nr++;
            end
            if (nr == 4) break;
            tick(); settle();
        end
        chk("arb.grants", 32'(ng), 32'd4);
        chk("arb.rsps", 32'(nr), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("arb.grant_id", 32'(g_id[i]), 32'(i % 2));
            chk("arb.rsp_sum", 32'(r_sum[i]), (i % 2) ? 32'd4 : 32'd2);
            chk("arb.rsp_id", 32'(r_id[i]), 32'(i % 2));
            if (i > 0) chk("arb.spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd6);
        end

        // Reset during ADD at k = 2 of a requester-0 operation.
        tick(); settle();
        chk("rst.pre_grant0", 32'(req0_ready), 32'd1);
        tick(); settle();
        chk("rst.busy_k0", 32'(busy), 32'd1);
        tick(); tick();
        rst_n = 1'b0;
        settle();
        chk_all_zero("rst.mid");
        tick(); settle();
        chk_all_zero("rst.held");
        rst_n = 1'b1;
        settle();
        chk("rst.grant0", 32'(req0_ready), 32'd1);
        chk("rst.grant1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rst.no_rsp", 32'(rsp_valid), 32'd0);
            tick(); settle();
        end

        // Exhaustive WIDTH = 4 sweep with one-cycle latency.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    e_v0 = 1'b1; e_a0 = 4'(ia); e_b0 = 4'(ib); e_c0 = 1'(ic);
                    tick();
                    e_v0 = 1'b0;
                    settle();
                    chk("exh.lat0", 32'(e_rv), 32'd0);
                    tick(); settle();
                    chk("exh.result", {26'd0, e_rv, e_cout, e_sum}, 32'(32 + ia + ib + ic));
                    tick();
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
